// File: rtl/uart_tx_frame.sv
// UART transmitter: accepts a byte on a valid/ready handshake and sends it LSB-first
// as start + 8 data + optional parity + 1/2 stop bits, using its own bit-period counter.
module uart_tx_frame #(
    parameter int SYS_RATE_DIV = 4,
    parameter int SYS_RATE     = 125_000_000 / (2 ** (SYS_RATE_DIV - 1)),
    parameter int BAND_RATE    = 115200,
    parameter int CNT_BAND     = SYS_RATE / BAND_RATE,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [2:0] dbg_state
);

    // Handshake: a byte transfers on a rising edge where tx_valid && tx_ready;
    // tx_ready is high only in IDLE and tx_valid outside IDLE is simply ignored.

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [13:0] CNT_LAST  = 14'(CNT_BAND - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

    state_t      state_q, state_d;
    logic [13:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic        tx_q, tx_d;
    logic        done_q, done_d;

    logic accept;
    logic bit_end;

    assign accept  = tx_valid && (state_q == IDLE);
    assign bit_end = (cnt_q == CNT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tx_valid) state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA:    if (bit_end && idx_q == 3'd7)
                         state_d = (PARITY_MODE != 0) ? PARITY : STOP;
            PARITY:  if (bit_end) state_d = STOP;
            STOP:    if (bit_end && idx_q == STOP_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bit timing and data path; idx counts data bits in DATA and stop bits in STOP.
    always_comb begin
        cnt_d   = (state_q == IDLE || bit_end) ? 14'd0 : cnt_q + 14'd1;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        if (state_q == IDLE) begin
            idx_d = 3'd0;
        end else if (bit_end) begin
            idx_d = (state_d != state_q) ? 3'd0 : idx_q + 3'd1;
        end
        if (accept) begin
            shift_d = tx_data;
            par_d   = (PARITY_MODE == 2) ? ~^tx_data : ^tx_data;
        end else if (state_q == DATA && bit_end) begin
            shift_d = {1'b0, shift_q[7:1]};
        end
    end

    // tx is computed from the state being entered so the pin comes straight off a flop.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        done_d = (state_q == STOP) && (state_d == IDLE);
    end

    assign tx        = tx_q;
    assign tx_done   = done_q;
    assign tx_ready  = (state_q == IDLE);
    assign tx_busy   = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmitter for the host link. It is the transmit-side counterpart of the RX path.
- Accepts a byte over a valid/ready handshake and serializes it LSB-first on tx.
- Frame format: start bit, 8 data bits, optional parity bit, then 1 or 2 stop bits.
- Contains its own bit-period counter, so no external baud strobe is needed. Sits between the result/readback logic and the board TX pin.

Parameters:
- SYS_RATE_DIV, 4, system clock divider exponent; clock freq = 125_000_000/(2**(SYS_RATE_DIV-1)).
- SYS_RATE, 125_000_000/(2**(SYS_RATE_DIV-1)), clock frequency in Hz (15_625_000 by default).
- BAND_RATE, 115200, serial bit rate.
- CNT_BAND, SYS_RATE/BAND_RATE, clock cycles per bit (135 by default); legal range 2..16383.
- PARITY_MODE, 0, parity selection: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- tx_data  input  8  byte to send; sampled only on acceptance.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a byte; equals (state==IDLE).
- tx  output  1  serial line; idle level is high.
- tx_busy  output  1  high while a frame is in progress (state!=IDLE).
- tx_done  output  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Reset (reset=0, asynchronous), applied immediately:
  - state=IDLE, tx=1, tx_done=0, bit counter=0, bit index=0, shift register=0.
  - Consequences: tx_ready=1, tx_busy=0.
- All registers update on the rising edge of clock. tx is driven directly from a register, with no combinational path to the pin.
- Handshake:
  - A byte is accepted on a clock edge where tx_valid && tx_ready.
  - tx_data is latched into the shift register at that edge; parity is computed from the latched byte.
  - tx_valid while tx_ready=0 is ignored, with no queuing. tx_valid may stay high across frames; the next byte is accepted on the first IDLE cycle.
- Latency: tx falls to 0 on the edge that accepts the byte, so the start bit is visible in the cycle after acceptance.
- FSM states and transitions:
  - IDLE: tx=1. On accept go to START.
  - START: tx=0 for CNT_BAND cycles, then go to DATA.
  - DATA: tx = shift[0]; each bit is held CNT_BAND cycles; the register shifts right at the end of each bit. After bit index 7 completes, go to PARITY if PARITY_MODE!=0, else STOP.
  - PARITY: tx = ^byte (PARITY_MODE=1) or ~^byte (PARITY_MODE=2), held CNT_BAND cycles, then go to STOP.
  - STOP: tx=1 for STOP_BITS*CNT_BAND cycles, then go to IDLE.
- Bit counter:
  - 14 bits wide; counts 0..CNT_BAND-1, wraps to 0 at the end of each bit, and is cleared on accept.
  - Every bit is exactly CNT_BAND clocks long; no fractional correction is applied.
- tx_done: registered. It is 1 in the first IDLE cycle after STOP ends and 0 otherwise.
- Frame timing:
  - Frame length = (1+8+P+STOP_BITS)*CNT_BAND cycles, where P = 1 if parity is enabled, else 0.
  - The minimum gap between frames is 1 IDLE cycle (tx=1). Default 8N1 frame = 1350 cycles.
- Reset mid-frame: the frame aborts immediately, tx returns to 1, and no tx_done pulse is produced. After reset releases, the block is in IDLE.
- A byte change on tx_data during a frame has no effect on the frame in progress.

Test Plan:
- Reset check: hold reset=0 with tx_valid=1 -> tx=1, tx_ready=1, tx_busy=0, tx_done=0. No frame starts until reset=1.
- Default 8N1 frame: send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 135 cycles. tx_done pulses 1350 cycles after the accept edge. tx_ready is low throughout the frame.
- Busy/back-to-back: hold tx_valid=1 with 0x3C then 0xFF, and toggle tx_data mid-frame:
  - the first frame is unaffected;
  - the second byte is accepted in the first IDLE cycle, giving exactly 1 idle-high cycle between frames.
- Parity:
  - PARITY_MODE=1: send 0x07 -> parity bit 1.
  - PARITY_MODE=2: send 0x07 -> parity bit 0.
  - In both cases the frame is 11*CNT_BAND cycles.
- Two stop bits: STOP_BITS=2 with 0x00 -> 9 low bits, then tx high for 270 cycles before tx_done.
- Reset mid-frame: assert reset during data bit 3 -> tx=1 asynchronously, with no tx_done. After release, send 0x55 -> a clean full frame.
